// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding, sizes,
// and the round-robin winner search.
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // The loop runs downward so that the requester closest to ptr (smallest
    // offset) is the last to be assigned and therefore wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// Plain 8-to-1 single-bit multiplexer.
module mux_8x1
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i,
    input  logic [IDX_W-1:0]   s,
    output logic               out
);

    assign out = i[s];

endmodule

// File: rtl/mux_arb_ctrl.sv
// Round-robin arbiter for 8 requesters with a bounded hold time, a one-cycle
// release gap between owners, and a data bit forwarded from the current owner.
module mux_arb_ctrl
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic [NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic               dout,
    output logic               timeout
);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic                 timeout_q, timeout_d;

    logic [IDX_W-1:0]     winner;
    logic                 hold_limit;
    logic                 mux_out;

    assign winner     = rr_pick(req, ptr_q);
    assign hold_limit = (hold_cnt_q == 8'(MAX_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE, RELEASE: begin
                gnt_d = '0;
                if (req != '0) begin
                    state_d    = GRANT;
                    gnt_d      = NUM_REQ'(1) << winner;
                    sel_d      = winner;
                    ptr_d      = winner + IDX_W'(1);
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (done || !req[sel_q] || hold_limit) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    // A forced release only counts if the owner still wanted the bus.
                    timeout_d = hold_limit && !done && req[sel_q];
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    mux_8x1 u_mux (
        .i   (data),
        .s   (sel_q),
        .out (mux_out)
    );

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = (state_q == GRANT);
    assign dout    = busy & mux_out;
    assign timeout = timeout_q;

endmodule

// File: doc/mux_arb_ctrl.md
MUX_ARB_CTRL -- requirements
Module: mux_arb_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, max consecutive grant cycles per owner, legal range 1..255.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port req, input, 8, request per requester; bit k = requester k.
REQ-005 SHALL have port done, input, 1, release strobe from current owner; ignored outside GRANT.
REQ-006 SHALL have port data, input, 8, one data bit per requester.
REQ-007 SHALL have port gnt, output, 8, one-hot grant, registered.
REQ-008 SHALL have port sel, output, 3, binary index of current/last owner, registered.
REQ-009 SHALL have port busy, output, 1, high exactly while state = GRANT.
REQ-010 SHALL have port dout, output, 1, data[sel] while busy, else 0.
REQ-011 SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-013 IDLE: req == 0 -> stay; req != 0 -> GRANT next edge, winner chosen from req sampled that edge.
REQ-014 Winner: first set req bit searching upward from ptr, wrapping 7 -> 0; ptr = (last owner + 1) mod 8.
REQ-015 Entering GRANT: gnt = one-hot(winner), sel = winner, hold_cnt = 0, ptr = winner + 1 mod 8 (7 wraps to 0).
REQ-016 Grant latency: req sampled at edge N -> gnt visible after edge N (one cycle from IDLE).
REQ-017 GRANT: hold_cnt increments each cycle; saturates, never wraps.
REQ-018 GRANT exits to RELEASE on done = 1, or req[sel] = 0, or hold_cnt = MAX_HOLD-1 (whichever first, same edge).
REQ-019 Simultaneous done and hold limit SHALL count as normal release: timeout stays 0.
REQ-020 timeout SHALL be 1 only during the RELEASE cycle following a hold-limit exit without done and with req[sel] still 1.
REQ-021 RELEASE lasts exactly one cycle; gnt = 0, busy = 0, sel holds last owner.
REQ-022 RELEASE: req != 0 -> GRANT (arbitrated per REQ-014); else -> IDLE.
REQ-023 Dead cycle between consecutive grants SHALL be exactly one cycle.
REQ-024 Single persistent requester SHALL be re-granted after the dead cycle when no other req bit set.
REQ-025 MAX_HOLD = 1: every grant lasts exactly one cycle.
REQ-026 dout combinational from data and sel, gated by busy; no registered data path.
REQ-027 done while IDLE or RELEASE SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force state = IDLE, gnt = 0, sel = 0, busy = 0, timeout = 0, hold_cnt = 0, ptr = 0.
REQ-029 Reset mid-GRANT SHALL drop gnt without passing through RELEASE; first post-reset arbitration starts at ptr = 0.
REQ-030 Release of rst_n SHALL take effect at the first rising clk edge with rst_n high.

Structure
REQ-031 State encoding (IDLE/GRANT/RELEASE), requester count 8, and index width 3 SHALL live in shared package mux_arb_pkg.
REQ-032 Data selection SHALL instantiate existing sub-module mux_8x1 (out, i = data, s = sel); gating by busy outside it.
REQ-033 Round-robin search SHALL be a single combinational function/block, no second FSM.

Verification
REQ-034 Reset then req = 8'h01 held, done never -> gnt = 8'h01 for 16 cycles, timeout = 1 in RELEASE, re-grant to 0 after one dead cycle.
REQ-035 req = 8'hFF, done pulsed each GRANT cycle 1 -> grant order 0,1,2,...,7,0 with one dead cycle between each.
REQ-036 ptr = 6 (last owner 5), req = 8'h21 -> winner 0 (wrap), next winner 5.
REQ-037 Owner 3 drops req[3] mid-grant, data = 8'h08 -> RELEASE next edge, dout = 1 while busy, 0 after, timeout = 0.
REQ-038 done and hold_cnt = MAX_HOLD-1 same cycle -> RELEASE, timeout = 0.
REQ-039 rst_n low mid-GRANT for owner 4 -> gnt = 0, sel = 0 immediately; after release req = 8'h30 -> winner 4.
